imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The processor only reads instruction memory; this block fills it.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words to instruction memory at consecutive word addresses.
- Holds the processor in reset until a load completes with a valid checksum, then releases it.

Parameters:
- ADDR_WIDTH, 8, word-address bits of instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a load when not busy.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte. A transfer occurs on a cycle where in_valid and in_ready are both 1.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  32  byte address of the write, equal to word_index<<2.
- imem_wdata  output  32  word to write.
- cpu_reset  output  1  processor reset; 1 while not successfully loaded.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- error  output  1  last load failed.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0. FSM goes to IDLE.
- Reset mid-load aborts immediately. Words already written stay in memory and are not rolled back.
- Stream format, all multi-byte fields MSB first:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - 4*N data bytes.
  - 1 checksum byte, equal to the XOR of all preceding bytes including both length bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
- IDLE / DONE / ERR:
  - in_ready=0 and busy=0.
  - start moves to LEN_HI and clears done, error, words_loaded, the byte counter, the word index and the checksum. It also sets cpu_reset=1.
  - In DONE: done=1, cpu_reset=0.
  - In ERR: error=1, cpu_reset=1.
- start is ignored in LEN_HI, LEN_LO, DATA and CHECK.
- LEN_HI and LEN_LO: in_ready=1 and busy=1; each state accepts one byte.
- On the LEN_LO transfer:
  - N > 2^ADDR_WIDTH: go to ERR; no writes occur.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA:
  - in_ready=1 continuously. The write pipeline never stalls input.
  - Each transfer shifts the byte into a word register: word = {word[23:0], in_data}.
  - A 2-bit byte counter wraps 3→0.
  - On the transfer where the counter is 3, the next cycle shows imem_we=1, imem_addr=word_index<<2 and imem_wdata=assembled word. In that same cycle word_index and words_loaded increment.
  - imem_we is 0 on all other cycles. imem_addr and imem_wdata hold their last values.
  - After the 4th byte of word N-1, go to CHECK.
- CHECK: in_ready=1; accepts one byte. Byte equal to the running XOR goes to DONE; otherwise ERR.
- The checksum accumulates on every accepted byte in LEN_HI, LEN_LO and DATA.
- A last-word write strobe that falls in the first CHECK cycle is still issued.
- in_valid while in_ready=0 has no effect, and the byte is not consumed. Gaps in in_valid only stall progress.
- cpu_reset falls in the cycle DONE is entered and never toggles otherwise.

Test Plan:
- Normal load: start, then stream 00 02 24 08 00 05 01 09 50 20 53. Required: exactly two imem_we pulses, (addr 0x0, data 0x24080005) then (addr 0x4, data 0x01095020). Afterwards done=1, error=0, cpu_reset=0, words_loaded=2.
- Bad checksum: same stream with final byte 54. Required: both writes still occur; error=1, done=0, cpu_reset=1.
- Length overflow (ADDR_WIDTH=8): start, then 01 01 (N=257). Required: ERR right after LEN_LO, no imem_we, in_ready=0, words_loaded=0.
- Empty load and handshake gaps:
  - Stream 00 00 00 → done=1, cpu_reset=0, no writes.
  - Repeat the normal load with in_valid low for 3 cycles between every byte → identical writes and final state.
  - Bytes offered in IDLE are not consumed.
- Reset mid-DATA: assert reset after 6 bytes of the normal stream. Required: all outputs at reset values asynchronously. A fresh start plus the full stream then completes with done=1.
- start ignored while busy: pulse start during DATA. Required: the load continues unaffected with the same writes and final state as the normal load.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed, XOR-checksummed byte stream,
// writes big-endian 32-bit words to consecutive addresses, and holds the CPU in reset until a load succeeds.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR} state_t;

  state_t          state, state_next;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [1:0]      byte_cnt;
  logic [CW-1:0]   word_idx;
  logic [7:0]      csum;
  logic [23:0]     word;

  logic            xfer;
  logic            idle_like;
  logic [15:0]     len_in;
  logic            last_word;

  assign xfer      = in_valid && in_ready;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign len_in    = {len_hi, in_data};
  // word_idx still holds the index of the word being completed
  assign last_word = (17'(word_idx) + 17'd1) == 17'(len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if ({1'b0, len_in} > CAPACITY) state_next = ERR;
          else if (len_in == 16'd0)      state_next = CHECK;
          else                           state_next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && byte_cnt == 2'd3 && last_word) state_next = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_next = (in_data == csum) ? DONE : ERR;
      end
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_next = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_next = LEN_HI;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      csum         <= '0;
      word         <= '0;
    end else begin
      imem_we <= 1'b0;

      if (idle_like && start) begin
        words_loaded <= '0;
        byte_cnt     <= '0;
        word_idx     <= '0;
        csum         <= '0;
      end

      if (xfer && state != CHECK) csum <= csum ^ in_data;
      if (xfer && state == LEN_HI) len_hi <= in_data;
      if (xfer && state == LEN_LO) len    <= len_in;

      if (xfer && state == DATA) begin
        word     <= {word[15:0], in_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          imem_we      <= 1'b1;
          imem_addr    <= 32'(word_idx) << 2;
          imem_wdata   <= {word, in_data};
          word_idx     <= word_idx + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed test-plan loads plus random loads,
// all checked against a stream-level reference model computed from the format rules.
module tb_imem_loader;

  localparam int AW = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int total = 0;
  int bad   = 0;
  wr_t got_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every write strobe, sampled away from the rising edge.
  always @(negedge clk) if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 64'(guard), 64'd0);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Reference: interpret the stream by its format rules and drive the checks.
  task automatic run_load(input string tag, input bq_t s, input int gap, input bit rnd_gap,
                          input bit mid_start);
    int        n;
    logic [7:0] x;
    bit        ok;
    wr_t       exp_q[$];
    got_q.delete();
    pulse_start();
    check({tag, "/start_busy"},  64'(busy),         64'd1);
    check({tag, "/start_words"}, 64'(words_loaded), 64'd0);
    check({tag, "/start_cpu"},   64'(cpu_reset),    64'd1);
    foreach (s[i]) begin
      if (mid_start && i == 4) start = 1'b1;
      send_byte(s[i], rnd_gap ? $urandom_range(0, gap) : gap);
      start = 1'b0;
    end
    repeat (3) tick();

    n = int'({s[0], s[1]});
    ok = 1'b0;
    if (n <= (1 << AW)) begin
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x ^= s[i];
      for (int w = 0; w < n; w++)
        exp_q.push_back({32'(w * 4), s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
      ok = (s[2 + 4 * n] == x);
    end

    check({tag, "/nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < got_q.size()) begin
      if (i < 2 || i == exp_q.size() - 1 || got_q[i] !== exp_q[i])
        check($sformatf("%s/wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    check({tag, "/done"},      64'(done),         64'(ok));
    check({tag, "/error"},     64'(error),        64'(!ok));
    check({tag, "/cpu_reset"}, 64'(cpu_reset),    64'(!ok));
    check({tag, "/busy"},      64'(busy),         64'd0);
    check({tag, "/in_ready"},  64'(in_ready),     64'd0);
    check({tag, "/words"},     64'(words_loaded), 64'(exp_q.size()));
  endtask

  initial begin
    bq_t normal, badck, ovf, empty, big, r;
    int  n;
    logic [7:0] x;

    normal = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h53};
    badck  = normal;
    badck[10] = 8'h54;
    ovf    = '{8'h01, 8'h01};
    empty  = '{8'h00, 8'h00, 8'h00};

    reset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (2) tick();
    check("rst/in_ready",  64'(in_ready),     64'd0);
    check("rst/cpu_reset", 64'(cpu_reset),    64'd1);
    check("rst/busy",      64'(busy),         64'd0);
    check("rst/done",      64'(done),         64'd0);
    check("rst/error",     64'(error),        64'd0);
    check("rst/imem_we",   64'(imem_we),      64'd0);
    check("rst/words",     64'(words_loaded), 64'd0);
    reset = 1'b0;
    tick();

    // Bytes offered while idle are not consumed.
    got_q.delete();
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (3) tick();
    check("idle/in_ready", 64'(in_ready),     64'd0);
    check("idle/busy",     64'(busy),         64'd0);
    in_valid = 1'b0;
    check("idle/nwrites",  64'(got_q.size()), 64'd0);

    run_load("normal",   normal, 0, 1'b0, 1'b0);
    check("normal/wr0_exact", 64'(got_q.size() > 0 ? got_q[0] : '0), {32'h0, 32'h24080005});
    check("normal/wr1_exact", 64'(got_q.size() > 1 ? got_q[1] : '0), {32'h4, 32'h01095020});
    run_load("badck",    badck,  0, 1'b0, 1'b0);
    run_load("overflow", ovf,    0, 1'b0, 1'b0);
    run_load("empty",    empty,  0, 1'b0, 1'b0);
    run_load("gaps",     normal, 3, 1'b0, 1'b0);
    run_load("midstart", normal, 0, 1'b0, 1'b1);

    // Reset mid-DATA: outputs return to reset values without a clock edge.
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(normal[i], 0);
    reset = 1'b1;
    #1;
    check("arst/in_ready",  64'(in_ready),     64'd0);
    check("arst/busy",      64'(busy),         64'd0);
    check("arst/cpu_reset", 64'(cpu_reset),    64'd1);
    check("arst/words",     64'(words_loaded), 64'd0);
    check("arst/addr",      64'(imem_addr),    64'd0);
    check("arst/wdata",     64'(imem_wdata),   64'd0);
    check("arst/we",        64'(imem_we),      64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_load("after_rst", normal, 0, 1'b0, 1'b0);

    // Exactly full memory.
    big = '{8'h01, 8'h00};
    for (int i = 0; i < 4 * (1 << AW); i++) big.push_back(8'($urandom));
    x = 8'h00;
    foreach (big[i]) x ^= big[i];
    big.push_back(x);
    run_load("full", big, 0, 1'b0, 1'b0);

    // Random loads with random gaps and occasionally corrupted checksums.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 6);
      r = '{8'(n >> 8), 8'(n)};
      for (int i = 0; i < 4 * n; i++) r.push_back(8'($urandom));
      x = 8'h00;
      foreach (r[i]) x ^= r[i];
      if ($urandom_range(0, 1) == 1) x ^= 8'(1 << $urandom_range(0, 7));
      r.push_back(x);
      run_load($sformatf("rnd%0d", t), r, 2, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
